key_event_decoder: RTL

Consumer of the 16-bit active-low key bitmap produced by the matrix keyboard scanner in the AHB_SEG_KEY subsystem. It synchronises and debounces each key, detects press (and optionally release) edges and encodes each one as a 4-bit key code. Events are queued in a small FIFO, with a valid/ready pop port that the AHB slave exposes to software.

---
 rtl/key_event_decoder_if.sv | 9 +
 rtl/key_event_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: valid/ready event pop port between the decoder and its consumer.
interface key_event_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic       evt_press;
    modport master (output evt_valid, evt_code, evt_press, input evt_ready);
    modport slave (input evt_valid, evt_code, evt_press, output evt_ready);
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: synchronises and debounces a 16-key active-low bitmap and queues key events in a FIFO.
// Define KEY_RELEASE_EVT_EN to also queue release events (evt_press = 0); default build queues presses only.
module key_event_decoder #(
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int DW = $clog2(SAMPLE_DIV)
) (
    input  logic                       clk,
    input  logic                       RSTn,
    input  logic [15:0]                key_raw,
    input  logic                       clear,
    key_event_decoder_if.master        evt,
    output logic [AW:0]                fifo_count,
    output logic                       overflow
);
    logic [15:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0] div_q, div_d;
    logic [15:0]   stable_q, stable_d, prev_q, prev_d, arm_q, arm_d;
    logic [3:0]    cnt_q [16];
    logic [3:0]    cnt_d [16];
    logic [15:0]   press_pend_q, press_pend_d, press_edge, press_clr;
`ifdef KEY_RELEASE_EVT_EN
    logic [15:0]   rel_pend_q, rel_pend_d, rel_edge, rel_clr;
`endif
    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [4:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          tick, pop, push, gnt_valid, gnt_press;
    logic [3:0]    gnt_code;

    // Sample tick, synchroniser and per-key debounce; a key held through reset stays
    // disarmed (no events) until it has been seen debounced-released on a tick.
    always_comb begin
        tick     = div_q == DW'(SAMPLE_DIV - 1);
        div_d    = tick ? '0 : div_q + 1'b1;
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        arm_d    = arm_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 16; i++) begin
            if (tick) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == 4'(STABLE_SAMPLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                if (sync2_q[i] && stable_q[i])
                    arm_d[i] = 1'b1;
            end
        end
    end

    // Edge capture into pending bits, lowest-index arbitration and FIFO bookkeeping
    always_comb begin
        press_edge = prev_q & ~stable_q & arm_q;
        gnt_valid  = 1'b0;
        gnt_press  = 1'b0;
        gnt_code   = '0;
        for (int i = 15; i >= 0; i--) begin
`ifdef KEY_RELEASE_EVT_EN
            if (rel_pend_q[i]) begin
                gnt_valid = 1'b1;
                gnt_press = 1'b0;
                gnt_code  = 4'(i);
            end
`endif
            if (press_pend_q[i]) begin
                gnt_valid = 1'b1;
                gnt_press = 1'b1;
                gnt_code  = 4'(i);
            end
        end
        pop          = (count_q != '0) && evt.evt_ready;
        push         = gnt_valid && ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);
        press_clr    = (push && gnt_press) ? 16'd1 << gnt_code : '0;
        press_pend_d = (press_pend_q & ~press_clr) | press_edge;
        ovf_d        = ovf_q | (|(press_edge & press_pend_q & ~press_clr));
`ifdef KEY_RELEASE_EVT_EN
        rel_edge     = ~prev_q & stable_q & arm_q;
        rel_clr      = (push && !gnt_press) ? 16'd1 << gnt_code : '0;
        rel_pend_d   = (rel_pend_q & ~rel_clr) | rel_edge;
        ovf_d        = ovf_d | (|(rel_edge & rel_pend_q & ~rel_clr));
`endif
        mem_d = mem_q;
        if (push)
            mem_d[wr_q] = {gnt_press, gnt_code};
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (clear) begin
            press_pend_d = '0;
`ifdef KEY_RELEASE_EVT_EN
            rel_pend_d   = '0;
`endif
            ovf_d        = 1'b0;
            wr_d         = '0;
            rd_d         = '0;
            count_d      = '0;
        end
    end

    // State registers, all returning to the released/empty state on reset
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q      <= 16'hFFFF;
            sync2_q      <= 16'hFFFF;
            div_q        <= '0;
            stable_q     <= 16'hFFFF;
            prev_q       <= 16'hFFFF;
            arm_q        <= '0;
            for (int i = 0; i < 16; i++)
                cnt_q[i] <= '0;
            press_pend_q <= '0;
`ifdef KEY_RELEASE_EVT_EN
            rel_pend_q   <= '0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            stable_q     <= stable_d;
            prev_q       <= prev_d;
            arm_q        <= arm_d;
            cnt_q        <= cnt_d;
            press_pend_q <= press_pend_d;
`ifdef KEY_RELEASE_EVT_EN
            rel_pend_q   <= rel_pend_d;
`endif
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    assign evt.evt_valid = count_q != '0;
    assign evt.evt_code  = (count_q != '0) ? mem_q[rd_q][3:0] : '0;
    assign evt.evt_press = (count_q != '0) & mem_q[rd_q][4];
    assign fifo_count    = count_q;
    assign overflow      = ovf_q;
endmodule
